// File: rtl/hough_pkg.sv
// Shared types and constants for the Hough pipeline tail.
// Pixel/column types, output_col geometry and its FSM states.
package hough_pkg;

    localparam int W     = 8;
    localparam int ROWS  = 256;
    localparam int COLS  = 256;
    localparam int LANES = 4;
    localparam int BEATS = ROWS / LANES;

    localparam int CW = $clog2(COLS);
    localparam int BW = $clog2(BEATS);
    localparam int AW = CW + BW;

    typedef logic [W-1:0] pixel_t;
    typedef pixel_t [ROWS-1:0] column_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } ocol_state_e;

endpackage

// File: rtl/col_serializer.sv
// Column capture register with LANES-wide shift-out.
// Ports: clock, reset_n, clear (sync), load, advance, col_in, beat_data.
module col_serializer #(
    parameter int W     = 8,
    parameter int ROWS  = 256,
    parameter int LANES = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                load,
    input  logic                advance,
    input  logic [ROWS*W-1:0]   col_in,
    output logic [LANES*W-1:0]  beat_data
);

    logic [ROWS*W-1:0] sr;

    // Row 0 sits in the low bits, so each advance exposes the next lanes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= col_in;
        end else if (advance) begin
            sr <= sr >> (LANES * W);
        end
    end

    assign beat_data = sr[LANES*W-1:0];

endmodule

// File: rtl/output_col.sv
// Column sink: serialises ROWS-pixel columns into LANES-pixel write beats.
// Ports: clock, reset_n, init, data_rdy_in, last_col_in, data_in,
//   data_req_out, wr_en, wr_addr {col,beat}, wr_data, col_count, frame_done.
// Macro OUTPUT_COL_STALL_EN adds input wr_ready (beat retires on wr_en & wr_ready).
module output_col
    import hough_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                init,
    input  logic                data_rdy_in,
    input  logic                last_col_in,
    input  logic [ROWS*W-1:0]   data_in,
`ifdef OUTPUT_COL_STALL_EN
    input  logic                wr_ready,
`endif
    output logic                data_req_out,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [LANES*W-1:0]  wr_data,
    output logic [CW-1:0]       col_count,
    output logic                frame_done
);

    ocol_state_e    state;
    ocol_state_e    state_nx;
    logic [BW-1:0]  beat;
    logic [BW-1:0]  beat_nx;
    logic [CW-1:0]  col;
    logic [CW-1:0]  col_nx;
    logic           last_q;
    logic           last_nx;
    logic           run;
    logic           adv;
    logic           xfer;
    logic           final_beat;
    logic           load;
    logic           shift;

`ifdef OUTPUT_COL_STALL_EN
    assign adv = wr_ready;
`else
    assign adv = 1'b1;
`endif

    assign final_beat = (state == DRAIN) && (beat == BW'(BEATS - 1));

    // run keeps the request low while reset is held; it rises on the first edge after.
    assign data_req_out = run & ((state == IDLE) | (final_beat & ~last_q & adv));
    assign xfer         = data_req_out & data_rdy_in & ~init;

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        col_nx   = col;
        last_nx  = last_q;
        load     = 1'b0;
        shift    = 1'b0;
        if (xfer) begin
            load    = 1'b1;
            last_nx = last_col_in;
        end
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    state_nx = DRAIN;
                    beat_nx  = '0;
                end
            end
            DRAIN: begin
                if (adv) begin
                    if (!final_beat) begin
                        beat_nx = beat + 1'b1;
                        shift   = 1'b1;
                    end else if (last_q) begin
                        state_nx = DONE;
                    end else begin
                        col_nx   = col + 1'b1;
                        beat_nx  = '0;
                        state_nx = xfer ? DRAIN : IDLE;
                    end
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            beat   <= '0;
            col    <= '0;
            last_q <= 1'b0;
        end else if (init) begin
            state  <= IDLE;
            beat   <= '0;
            col    <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            beat   <= beat_nx;
            col    <= col_nx;
            last_q <= last_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    col_serializer #(
        .W     (W),
        .ROWS  (ROWS),
        .LANES (LANES)
    ) u_ser (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (init),
        .load      (load),
        .advance   (shift),
        .col_in    (data_in),
        .beat_data (wr_data)
    );

    assign wr_en      = (state == DRAIN);
    assign wr_addr    = {col, beat};
    assign col_count  = col;
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_output_col.sv
// Self-checking bench for output_col.
// Table-driven column scenarios plus hand-written abort/reset/wrap/stall sequences.
module tb_output_col;

    localparam int W     = 8;
    localparam int ROWS  = 256;
    localparam int LANES = 4;
    localparam int BEATS = 64;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              init = 1'b0;
    logic              data_rdy_in = 1'b0;
    logic              last_col_in = 1'b0;
    logic [ROWS*W-1:0] data_in = '0;
    logic              data_req_out;
    logic              wr_en;
    logic [13:0]       wr_addr;
    logic [31:0]       wr_data;
    logic [7:0]        col_count;
    logic              frame_done;
`ifdef OUTPUT_COL_STALL_EN
    logic              wr_ready = 1'b1;
`endif

    output_col dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .init         (init),
        .data_rdy_in  (data_rdy_in),
        .last_col_in  (last_col_in),
        .data_in      (data_in),
`ifdef OUTPUT_COL_STALL_EN
        .wr_ready     (wr_ready),
`endif
        .data_req_out (data_req_out),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .col_count    (col_count),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [7:0]  col;
    } beat_t;

    typedef struct {
        int n;
        int gap;
        bit last;
        int exp_wr;
        int exp_col;
        bit exp_done;
    } vec_t;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    wr_cnt = 0;
    int    last_cyc = 0;
    int    exp_col = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int seed, input int r);
        return 8'(r + seed * 13);
    endfunction

    function automatic logic [ROWS*W-1:0] mk_col(input int seed);
        logic [ROWS*W-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*W +: W] = pix(seed, r);
        return v;
    endfunction

    function automatic logic [31:0] exp_beat(input int seed, input int k);
        logic [31:0] d;
        for (int l = 0; l < LANES; l++) d[l*W +: W] = pix(seed, k * LANES + l);
        return d;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Write-port monitor: every retired beat is checked against the scoreboard.
    always @(negedge clock) begin
        logic  go;
        beat_t e;
`ifdef OUTPUT_COL_STALL_EN
        go = wr_en & wr_ready;
`else
        go = wr_en;
`endif
        if (go) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_data", 64'(wr_data), 64'(e.data));
                chk("col_count", 64'(col_count), 64'(e.col));
            end
            wr_cnt++;
            last_cyc = cyc;
        end
    end

    // Offer a column; push its expected beats when the handshake is seen.
    task automatic send(input int seed, input bit last);
        int    t;
        beat_t e;
        logic [7:0] c8;
        t = 0;
        data_in = mk_col(seed);
        last_col_in = last;
        data_rdy_in = 1'b1;
        @(negedge clock);
        while (!data_req_out && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (!data_req_out) begin
            chk("req_timeout", 64'd0, 64'd1);
        end else begin
            c8 = 8'(exp_col);
            for (int k = 0; k < BEATS; k++) begin
                e.addr = {c8, 6'(k)};
                e.data = exp_beat(seed, k);
                e.col  = c8;
                sb.push_back(e);
            end
            if (!last) exp_col = (exp_col + 1) % 256;
        end
        @(posedge clock);
        #1;
        data_rdy_in = 1'b0;
        last_col_in = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (wr_en && t < 2000) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("drain_timeout", 64'(wr_en), 64'd0);
    endtask

    task automatic do_init();
        init = 1'b1;
        @(posedge clock);
        #1;
        init = 1'b0;
        sb.delete();
        exp_col = 0;
        chk("init_wr_en", 64'(wr_en), 64'd0);
        chk("init_col", 64'(col_count), 64'd0);
        chk("init_req", 64'(data_req_out), 64'd1);
        chk("init_done", 64'(frame_done), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   base;
        int   first;
        int   held;

        tbl[0] = '{1, 0, 1'b1, 64, 0, 1'b1};
        tbl[1] = '{3, 0, 1'b1, 192, 2, 1'b1};
        tbl[2] = '{3, 10, 1'b1, 192, 2, 1'b1};
        tbl[3] = '{2, 1, 1'b0, 128, 2, 1'b0};

        #2 reset_n = 1'b0;
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_req", 64'(data_req_out), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_col", 64'(col_count), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_req", 64'(data_req_out), 64'd1);

        for (int i = 0; i < 4; i++) begin
            do_init();
            base = wr_cnt;
            first = 0;
            for (int c = 0; c < tbl[i].n; c++) begin
                send(i * 10 + c, tbl[i].last && (c == tbl[i].n - 1));
                if (c == 0) first = cyc;
                if (tbl[i].gap > 0 && c < tbl[i].n - 1) begin
                    wait_drain();
                    for (int g = 0; g < tbl[i].gap - 1; g++) begin
                        chk("idle_req", 64'(data_req_out), 64'd1);
                        @(posedge clock);
                        #1;
                    end
                end
            end
            wait_drain();
            chk("wr_count", 64'(wr_cnt - base), 64'(tbl[i].exp_wr));
            chk("wr_span", 64'(last_cyc - first + 1),
                64'(tbl[i].exp_wr + tbl[i].gap * (tbl[i].n - 1)));
            chk("end_col", 64'(col_count), 64'(tbl[i].exp_col));
            chk("end_done", 64'(frame_done), 64'(tbl[i].exp_done));
            chk("end_req", 64'(data_req_out), 64'(!tbl[i].exp_done));
            chk("sb_empty", 64'(sb.size()), 64'd0);
            if (tbl[i].exp_done) begin
                base = wr_cnt;
                data_rdy_in = 1'b1;
                repeat (4) @(posedge clock);
                #1;
                data_rdy_in = 1'b0;
                chk("done_ignores_rdy", 64'(wr_cnt - base), 64'd0);
                chk("done_sticky", 64'(frame_done), 64'd1);
            end
        end

        // init in the middle of column 5
        do_init();
        for (int c = 0; c < 6; c++) send(100 + c, 1'b0);
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        init = 1'b1;
        @(posedge clock);
        #1;
        init = 1'b0;
        chk("abort_left", 64'(sb.size()), 64'd43);
        sb.delete();
        exp_col = 0;
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_col", 64'(col_count), 64'd0);
        chk("abort_req", 64'(data_req_out), 64'd1);
        held = wr_cnt;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        chk("abort_no_wr", 64'(wr_cnt - held), 64'd0);

        // async reset between edges while draining column 1
        send(200, 1'b0);
        send(201, 1'b0);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        sb.delete();
        exp_col = 0;
        chk("arst_wr_en", 64'(wr_en), 64'd0);
        chk("arst_req", 64'(data_req_out), 64'd0);
        chk("arst_col", 64'(col_count), 64'd0);
        chk("arst_addr", 64'(wr_addr), 64'd0);
        chk("arst_data", 64'(wr_data), 64'd0);
        chk("arst_done", 64'(frame_done), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("arst_rel_req", 64'(data_req_out), 64'd1);
        chk("arst_rel_wr_en", 64'(wr_en), 64'd0);

        // full wrap of the column counter without last_col
        do_init();
        last_col_in = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        last_col_in = 1'b0;
        for (int c = 0; c < 256; c++) send(300 + c, 1'b0);
        wait_drain();
        chk("wrap_col", 64'(col_count), 64'd0);
        chk("wrap_done", 64'(frame_done), 64'd0);
        chk("wrap_req", 64'(data_req_out), 64'd1);
        chk("wrap_sb", 64'(sb.size()), 64'd0);

`ifdef OUTPUT_COL_STALL_EN
        do_init();
        base = wr_cnt;
        send(500, 1'b1);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        wr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk("stall_addr", 64'(wr_addr), 64'({8'd0, 6'd10}));
            chk("stall_data", 64'(wr_data), 64'(exp_beat(500, 10)));
            chk("stall_wr_en", 64'(wr_en), 64'd1);
            @(posedge clock);
            #1;
        end
        wr_ready = 1'b1;
        wait_drain();
        chk("stall_beats", 64'(wr_cnt - base), 64'd64);
        chk("stall_done", 64'(frame_done), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
